// File: rtl/color_convert_pkg.sv
// Shared encodings and luma weights for the colour conversion pipeline.
// Coefficients are 8-bit fixed point fractions of 256 (BT.601-style luma).
package color_convert_pkg;

    typedef enum logic [1:0] {
        MODE_PASS   = 2'd0,
        MODE_LUMA   = 2'd1,
        MODE_AVG    = 2'd2,
        MODE_THRESH = 2'd3
    } mode_e;

    localparam int LUMA_R = 77;
    localparam int LUMA_G = 150;
    localparam int LUMA_B = 29;

endpackage

// File: rtl/color_convert_luma_mac.sv
// Combinational weighted sum 77*R + 150*G + 29*B feeding the stage-1 register.
module luma_mac
    import color_convert_pkg::*;
#(
    parameter int CH_W = 4
) (
    input  logic [CH_W-1:0] r,
    input  logic [CH_W-1:0] g,
    input  logic [CH_W-1:0] b,
    output logic [CH_W+9:0] sum
);

    localparam int SW = CH_W + 10;

    always_comb begin
        sum = SW'(LUMA_R) * SW'(r) + SW'(LUMA_G) * SW'(g) + SW'(LUMA_B) * SW'(b);
    end

endmodule

// File: rtl/color_convert.sv
// Two-stage pixel converter: pass, luma, average or luma threshold, with the
// mode/threshold latched per frame on the SOF beat and a single global stall.
module color_convert
    import color_convert_pkg::*;
#(
    parameter int CH_W   = 4,
    parameter int COEF_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic [3*CH_W-1:0] i_pix_data,
    input  logic              i_pix_valid,
    input  logic              i_pix_sof,
    input  logic              i_pix_eol,
    output logic              o_pix_ready,
    input  logic [1:0]        i_mode,
    input  logic [CH_W-1:0]   i_thresh,
    output logic [3*CH_W-1:0] o_pix_data,
    output logic              o_pix_valid,
    output logic              o_pix_sof,
    output logic              o_pix_eol,
    input  logic              i_pix_ready
);

    localparam int PW = 3 * CH_W;
    localparam int SW = CH_W + 10;
    localparam logic [SW-1:0] ROUND = SW'(1) << (COEF_W - 1);
    localparam logic [SW-1:0] MAXV  = SW'((1 << CH_W) - 1);

    logic            en;
    logic            in_xfer;
    logic            sof_xfer;
    mode_e           mode_q;
    mode_e           cur_mode;
    logic [CH_W-1:0] thresh_q;
    logic [CH_W-1:0] cur_thresh;
    logic [SW-1:0]   mac_sum;

    logic            s1_valid;
    logic            s1_sof;
    logic            s1_eol;
    logic [PW-1:0]   s1_pix;
    mode_e           s1_mode;
    logic [CH_W-1:0] s1_thresh;
    logic [SW-1:0]   s1_sum;

    logic [SW-1:0]   luma_rnd;
    logic [SW-1:0]   y_full;
    logic [CH_W-1:0] y;
    logic [CH_W+1:0] avg_sum;
    logic [CH_W-1:0] avg;
    logic [PW-1:0]   result;

    assign en          = !o_pix_valid || i_pix_ready;
    assign o_pix_ready = en;
    assign in_xfer     = i_pix_valid && en;
    assign sof_xfer    = in_xfer && i_pix_sof;

    // The SOF beat itself must already see the newly requested settings.
    always_comb begin
        cur_mode   = mode_q;
        cur_thresh = thresh_q;
        if (sof_xfer) begin
            cur_mode   = mode_e'(i_mode);
            cur_thresh = i_thresh;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            mode_q   <= MODE_PASS;
            thresh_q <= '0;
        end else if (sof_xfer) begin
            mode_q   <= cur_mode;
            thresh_q <= cur_thresh;
        end
    end

    luma_mac #(.CH_W(CH_W)) u_luma_mac (
        .r   (i_pix_data[3*CH_W-1:2*CH_W]),
        .g   (i_pix_data[2*CH_W-1:CH_W]),
        .b   (i_pix_data[CH_W-1:0]),
        .sum (mac_sum)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            s1_valid  <= 1'b0;
            s1_sof    <= 1'b0;
            s1_eol    <= 1'b0;
            s1_pix    <= '0;
            s1_mode   <= MODE_PASS;
            s1_thresh <= '0;
            s1_sum    <= '0;
        end else if (en) begin
            s1_valid  <= in_xfer;
            s1_sof    <= in_xfer && i_pix_sof;
            s1_eol    <= in_xfer && i_pix_eol;
            s1_pix    <= i_pix_data;
            s1_mode   <= cur_mode;
            s1_thresh <= cur_thresh;
            s1_sum    <= mac_sum;
        end
    end

    // Stage 2: round/clamp luma, truncating average, then select by mode.
    always_comb begin
        luma_rnd = s1_sum + ROUND;
        y_full   = luma_rnd >> COEF_W;
        y        = (y_full > MAXV) ? '1 : CH_W'(y_full);
        avg_sum  = (CH_W+2)'(s1_pix[3*CH_W-1:2*CH_W])
                 + ((CH_W+2)'(s1_pix[2*CH_W-1:CH_W]) << 1)
                 + (CH_W+2)'(s1_pix[CH_W-1:0]);
        avg      = CH_W'(avg_sum >> 2);
        case (s1_mode)
            MODE_PASS:   result = s1_pix;
            MODE_LUMA:   result = {3{y}};
            MODE_AVG:    result = {3{avg}};
            MODE_THRESH: result = (y >= s1_thresh) ? {PW{1'b1}} : {PW{1'b0}};
            default:     result = s1_pix;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_pix_valid <= 1'b0;
            o_pix_data  <= '0;
            o_pix_sof   <= 1'b0;
            o_pix_eol   <= 1'b0;
        end else if (en) begin
            o_pix_valid <= s1_valid;
            o_pix_data  <= s1_valid ? result : '0;
            o_pix_sof   <= s1_valid && s1_sof;
            o_pix_eol   <= s1_valid && s1_eol;
        end
    end

endmodule

// File: doc/color_convert.md
COLOR_CONVERT -- requirements
Module: color_convert

Interface
REQ-001 The module SHALL have parameter CH_W, default 4, giving bits per colour channel (legal 2..12).
REQ-002 The module SHALL have parameter COEF_W, default 8, giving fractional bits of the luma coefficients (fixed at 8 in this generation).
REQ-003 i_clk  in  1  sole clock; all state SHALL be on its rising edge.
REQ-004 i_rstn  in  1  reset; asynchronous, active-low.
REQ-005 i_pix_data  in  3*CH_W  input pixel {R,G,B}, R in the MSBs.
REQ-006 i_pix_valid  in  1  input beat valid.
REQ-007 i_pix_sof  in  1  start-of-frame flag; qualified by i_pix_valid.
REQ-008 i_pix_eol  in  1  end-of-line flag; qualified by i_pix_valid.
REQ-009 o_pix_ready  out  1  upstream may transfer when high.
REQ-010 i_mode  in  2  requested mode: 0 pass, 1 luma, 2 average, 3 threshold.
REQ-011 i_thresh  in  CH_W  threshold for mode 3.
REQ-012 o_pix_data  out  3*CH_W  result pixel.
REQ-013 o_pix_valid  out  1  output beat valid.
REQ-014 o_pix_sof, o_pix_eol  out  1 each  sidebands delayed in step with data.
REQ-015 i_pix_ready  in  1  downstream accepts when high.

Function
REQ-016 An input transfer SHALL occur on a cycle with i_pix_valid and o_pix_ready both high; an output transfer SHALL occur on a cycle with o_pix_valid and i_pix_ready both high.
REQ-017 The datapath SHALL be a 2-stage pipeline with global enable en = !o_pix_valid || i_pix_ready; o_pix_ready SHALL equal en.
REQ-018 Latency SHALL be 2 cycles from input transfer to o_pix_valid when never stalled; throughput SHALL be one pixel per cycle.
REQ-019 While en is low, every pipeline register and output SHALL hold its value; no beat SHALL be dropped or duplicated.
REQ-020 Stage 1 SHALL register sum = 77*R + 150*G + 29*B, width CH_W+10, together with valid, sof, eol, the raw pixel and the active mode.
REQ-021 Luma SHALL be Y = (sum + 128) >> 8, clamped to 2^CH_W-1.
REQ-022 Average SHALL be A = (R + 2*G + B) >> 2, with truncation.
REQ-023 Mode 0 SHALL output the input pixel unchanged.
REQ-024 Modes 1 and 2 SHALL replicate Y or A, respectively, onto all three channels.
REQ-025 Mode 3 SHALL output all-ones on every channel when Y >= threshold, else all-zeros.
REQ-026 The active mode and threshold registers SHALL load i_mode and i_thresh only on an input transfer with i_pix_sof high, and that beat SHALL already use the new values.
REQ-027 i_mode and i_thresh changes mid-frame SHALL have no effect until the next SOF transfer.
REQ-028 When o_pix_valid is low, o_pix_data SHALL be 0.
REQ-029 Stage valid bits SHALL clear when en is high and no input transfer occurs.

Reset
REQ-030 Assertion of i_rstn low SHALL asynchronously clear all valid bits, o_pix_data, o_pix_sof and o_pix_eol to 0.
REQ-031 Reset SHALL set the active mode to 0 (pass) and the active threshold to 0.
REQ-032 Beats in flight at reset SHALL be discarded.
REQ-033 The first transfer after reset deassertion SHALL be accepted on the first edge at which i_pix_valid is high.

Structure
REQ-034 Package color_convert_pkg SHALL hold the mode encodings (MODE_PASS, MODE_LUMA, MODE_AVG, MODE_THRESH) and the coefficients LUMA_R=77, LUMA_G=150 and LUMA_B=29.
REQ-035 A single sub-module luma_mac SHALL compute the stage-1 weighted sum combinationally, parametrised by CH_W.

Verification (CH_W=4)
REQ-036 Luma: SOF with mode 1; pixels 0xFFF, 0xF00 -> outputs 0xFFF, 0x555 after 2 cycles each.
REQ-037 Average: SOF with mode 2; pixel 0x0F0 -> output 0x777.
REQ-038 Threshold: SOF with mode 3 and i_thresh=8; pixels 0x0F0, 0xF00 -> outputs 0xFFF, 0x000.
REQ-039 Mid-frame mode change: frame starts in mode 1; i_mode set to 0 mid-frame -> remaining beats stay luma; next SOF beat passes through raw.
REQ-040 Backpressure: continuous input with i_pix_ready low for 3 cycles -> o_pix_ready low, output held, and all 10 beats delivered in order with sof and eol aligned.
REQ-041 Reset: i_rstn pulsed low with 2 beats in flight -> o_pix_valid 0 immediately, no stale beat emitted after release, and active mode back to pass.
